// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: default stage widths and the skid-buffer state encoding.
package pipe_skid_reg_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_NLANES = 3;
    localparam int PIPE_CTRL_W = 2;
    localparam int PIPE_RD_W   = 5;

    // Encoding doubles as the occupancy count (entries held).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Flattened payload: all lanes, writeback select, write enable, destination index.
    function automatic int payload_width(input int dw, input int nl, input int cw, input int rw);
        return dw * nl + cw + 1 + rw;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous active-low clear.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Load on enable; clear while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with registered ready/valid,
// flush, occupancy report and saturating upstream stall counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int NLANES = PIPE_NLANES,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int RD_W   = PIPE_RD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLANES*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic                     in_we,
    input  logic [RD_W-1:0]          in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLANES*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic                     out_we,
    output logic [RD_W-1:0]          out_rd,
    output logic [1:0]               occupancy,
    output logic [15:0]              stall_cnt
);

    localparam int PW    = payload_width(DATA_W, NLANES, CTRL_W, RD_W);
    localparam int LANES = NLANES * DATA_W;

    skid_state_e    r_state, w_state_nxt;
    logic           r_in_ready, r_out_valid;
    logic [15:0]    r_stall_cnt;

    logic           w_in_fire, w_out_fire;
    logic           w_main_en, w_skid_en, w_main_from_skid;
    logic [PW-1:0]  w_in_pay, w_main_d, w_main_q, w_skid_q;
    logic           w_main_we;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_in_pay   = {in_data, in_ctrl, in_we, in_rd};
    assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_pay;

    // Next-state and register-load decode; flush wins over any handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_en        = 1'b0;
        w_skid_en        = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_en   = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_in_fire, w_out_fire})
                    2'b11: w_main_en = 1'b1;
                    2'b10: begin
                        w_skid_en   = 1'b1;
                        w_state_nxt = ST_TWO;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (w_out_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_main_en        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush)
            w_state_nxt = ST_EMPTY;
    end

    // State plus ready/valid flops decoded from the next state, so neither
    // handshake output has a combinational path from out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Saturating count of cycles upstream was held off; flush does not touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (in_valid && !r_in_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_main_en),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_skid_en),
        .i_d  (w_in_pay),
        .o_q  (w_skid_q)
    );

    assign out_data  = w_main_q[PW-1 -: LANES];
    assign out_ctrl  = w_main_q[RD_W+1 +: CTRL_W];
    assign w_main_we = w_main_q[RD_W];
    assign out_rd    = w_main_q[RD_W-1:0];
    // A stale write enable must never escape with an empty stage.
    assign out_we    = w_main_we & r_out_valid;

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, back-pressure, flush,
// write-enable gating and stall counter saturation.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int NLANES = 3;
    localparam int CTRL_W = 2;
    localparam int RD_W   = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [NLANES*DATA_W-1:0] in_data;
    logic [CTRL_W-1:0]        in_ctrl;
    logic                     in_we;
    logic [RD_W-1:0]          in_rd;
    logic                     out_valid;
    logic                     out_ready;
    logic [NLANES*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]        out_ctrl;
    logic                     out_we;
    logic [RD_W-1:0]          out_rd;
    logic [1:0]               occupancy;
    logic [15:0]              stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_skid_reg #(
        .DATA_W (DATA_W),
        .NLANES (NLANES),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_we    (out_we),
        .out_rd    (out_rd),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper lanes carry fixed tags so lane placement is also exercised.
    task automatic put(input logic [31:0] lane0);
        in_data = {32'hC0DE_0002, 32'hC0DE_0001, lane0};
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; in_we = 1'b0; in_rd = '0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b1;

        // Streaming: one per cycle, one cycle latency, occupancy stays 1.
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 2'd2; in_rd = 5'd17;
        put(32'h11); tick();
        chk("s0_lane0", out_data[31:0], 32'h11);
        chk("s0_full", out_data, {32'hC0DE_0002, 32'hC0DE_0001, 32'h11});
        chk("s0_ctrl", out_ctrl, 2'd2);
        chk("s0_rd", out_rd, 5'd17);
        chk("s0_occ", occupancy, 1);
        put(32'h22); tick();
        chk("s1_lane0", out_data[31:0], 32'h22);
        chk("s1_occ", occupancy, 1);
        put(32'h33); tick();
        chk("s2_lane0", out_data[31:0], 32'h33);
        chk("s2_occ", occupancy, 1);
        in_valid = 1'b0; tick();
        chk("s3_valid", out_valid, 0);
        chk("s3_occ", occupancy, 0);

        // Asynchronous reset mid-stream with in_valid held high.
        out_ready = 1'b0; in_valid = 1'b1; in_we = 1'b1; put(32'h44); tick();
        chk("r0_occ", occupancy, 1);
        rst = 1'b0; #1;
        chk("r_async_valid", out_valid, 0);
        chk("r_async_ready", in_ready, 1);
        chk("r_async_occ", occupancy, 0);
        chk("r_async_stall", stall_cnt, 0);
        chk("r_async_data", out_data, 0);
        chk("r_async_ctrl", out_ctrl, 0);
        chk("r_async_we", out_we, 0);
        chk("r_async_rd", out_rd, 0);
        tick();
        chk("r_hold_occ", occupancy, 0);
        rst = 1'b1; in_we = 1'b0; put(32'h55); tick();
        chk("r_first_occ", occupancy, 1);
        chk("r_first_lane0", out_data[31:0], 32'h55);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("r_drain_occ", occupancy, 0);

        // Back-pressure: A, B fill both entries, C is held off then drains in order.
        out_ready = 1'b0; in_valid = 1'b1; put(32'hA); tick();
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_ready", in_ready, 1);
        put(32'hB); tick();
        chk("bp_b_occ", occupancy, 2);
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_lane0", out_data[31:0], 32'hA);
        put(32'hC); tick();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_lane0", out_data[31:0], 32'hA);
        chk("bp_hold_stall", stall_cnt, 1);
        out_ready = 1'b1; tick();
        chk("bp_out_b", out_data[31:0], 32'hB);
        chk("bp_out_b_occ", occupancy, 1);
        chk("bp_out_b_ready", in_ready, 1);
        tick();
        chk("bp_out_c", out_data[31:0], 32'hC);
        chk("bp_out_c_valid", out_valid, 1);
        in_valid = 1'b0; tick();
        chk("bp_empty_occ", occupancy, 0);
        chk("bp_stall", stall_cnt, 2);

        // Flush while full with a new entry offered: everything dropped.
        out_ready = 1'b0; in_valid = 1'b1; put(32'hD1); tick();
        put(32'hD2); tick();
        chk("fl_full_occ", occupancy, 2);
        flush = 1'b1; put(32'hD3); tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl_after_occ", occupancy, 0);
        // Flush in ONE with simultaneous in_fire and out_fire.
        in_valid = 1'b1; put(32'hE1); tick();
        chk("fl1_occ", occupancy, 1);
        flush = 1'b1; out_ready = 1'b1; put(32'hE2); tick();
        chk("fl1_after_occ", occupancy, 0);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl1_after_valid", out_valid, 0);
        chk("fl_stall", stall_cnt, 3);

        // Write enable only visible while the stage holds a valid entry.
        in_valid = 1'b1; in_we = 1'b1; put(32'hF1); tick();
        chk("we_on", out_we, 1);
        chk("we_valid", out_valid, 1);
        in_valid = 1'b0; tick();
        chk("we_off_valid", out_valid, 0);
        chk("we_off", out_we, 0);
        in_we = 1'b0;

        // Long back-pressure: counter saturates rather than wrapping.
        out_ready = 1'b0; in_valid = 1'b1; put(32'h71); tick();
        put(32'h72); tick();
        chk("sat_fill_occ", occupancy, 2);
        repeat (65531) tick();
        chk("sat_near", stall_cnt, 16'hFFFE);
        repeat (70000 - 65531) tick();
        chk("sat_max", stall_cnt, 16'hFFFF);
        chk("sat_occ", occupancy, 2);
        chk("sat_lane0", out_data[31:0], 32'h71);
        flush = 1'b1; in_valid = 1'b0; tick();
        flush = 1'b0;
        chk("sat_flush_stall", stall_cnt, 16'hFFFF);
        chk("sat_flush_occ", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
